// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types, defaults and helpers for round-robin stream muxes
//
// Contents:
//   clog2_min1(n) : index width for n items, never below 1 bit
//   DEF_N, DEF_W  : default channel count and data width
//   arb_state_t   : ARB (free round-robin) / LOCK (held on one channel mid-packet)
package mux_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with rotating start pointer
//
// Parameters:
//   N       : number of requesters (>= 1)
// Ports:
//   req     : input  [N-1:0]     request per requester
//   ptr     : input  [SEL_W-1:0] highest-priority index, must be < N
//   gnt_vld : output             some requester is granted
//   gnt_idx : output [SEL_W-1:0] index of first set req at or after ptr, modulo N
import mux_pkg::*;

module rr_arbiter #(
    parameter int N     = DEF_N,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        if (s >= N) s = s - N;
        return s;
    endfunction

    // Scan from the farthest position back to ptr so the last hit written
    // is the closest one to ptr, which is the winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-to-1 round-robin stream multiplexer with registered output
//
// Optional feature macro: MUX_RR_PKT_LOCK_EN (adds in_last/out_last and packet locking)
//
// Parameters:
//   N : number of input channels (>= 1)
//   W : data width per channel
// Ports:
//   clk       : input                clock, rising edge
//   rst       : input                asynchronous reset, active high
//   in_data   : input  [N*W-1:0]     channel i at [i*W +: W]
//   in_valid  : input  [N-1:0]       per-channel valid
//   in_ready  : output [N-1:0]       per-channel accept, one-hot or zero
//   in_last   : input  [N-1:0]       (macro only) last word of a packet
//   out_data  : output [W-1:0]       registered selected data
//   out_valid : output               out_data holds an untaken word
//   out_ready : input                consumer accepts out_data
//   out_sel   : output [SEL_W-1:0]   channel that supplied out_data
//   out_last  : output               (macro only) registered in_last of that word
import mux_pkg::*;

module mux_rr_stream #(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
`ifdef MUX_RR_PKT_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [N-1:0]     req;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             load;
    logic             xfer;

    // Output register can take a word when empty or being drained this cycle.
    assign load = !out_valid || out_ready;
    assign xfer = load && gnt_vld && !rst;

`ifdef MUX_RR_PKT_LOCK_EN
    arb_state_t       state;
    logic [SEL_W-1:0] lock_ch;
    logic             gnt_last;

    // While locked, only the owning channel may request.
    always_comb begin
        req = in_valid;
        if (state == LOCK) begin
            req          = '0;
            req[lock_ch] = in_valid[lock_ch];
        end
    end

    assign gnt_last = in_last[gnt_idx];
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    assign ptr_next = (int'(gnt_idx) == N - 1) ? '0 : SEL_W'(int'(gnt_idx) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
`ifdef MUX_RR_PKT_LOCK_EN
            out_last  <= 1'b0;
            state     <= ARB;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            if (gnt_vld) begin
                out_data  <= in_data[int'(gnt_idx)*W +: W];
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
`ifdef MUX_RR_PKT_LOCK_EN
                out_last  <= gnt_last;
                // Pointer moves on packet boundaries only, so a packet's
                // words are never interleaved with other channels.
                if (gnt_last) begin
                    ptr   <= ptr_next;
                    state <= ARB;
                end else begin
                    state   <= LOCK;
                    lock_ch <= gnt_idx;
                end
`else
                ptr       <= ptr_next;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - self-checking directed bench for mux_rr_stream (N=4, W=8)
module tb_mux_rr_stream;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [N-1:0] in_last;
    logic         out_last;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;

    int checks;
    int failures;

    mux_rr_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUX_RR_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

`ifndef MUX_RR_PKT_LOCK_EN
    assign out_last = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_data;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, check ready before the edge, check registers after it.
    task automatic step(input int idx, input logic [3:0] v, input logic ordy,
                        input logic [3:0] erdy, input logic eov, input logic [7:0] edata,
                        input logic [1:0] esel);
        in_valid  = v;
        out_ready = ordy;
        #1;
        chk("in_ready", idx, 32'(in_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk("out_valid", idx, 32'(out_valid), 32'(eov));
        chk("out_data", idx, 32'(out_data), 32'(edata));
        chk("out_sel", idx, 32'(out_sel), 32'(esel));
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;

        //            valid    ordy  rdy      ov    data   sel
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1};
        vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1};
        vecs[13] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hC2, 2'd2};
        vecs[16] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[17] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3};
        vecs[18] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};

        // Reset held across edges with every channel valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 0, 32'(in_ready), 32'h0);
        chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
        chk("rst_out_sel", 0, 32'(out_sel), 32'h0);
        chk("rst_out_data", 0, 32'(out_data), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++)
            step(i, vecs[i].valid, vecs[i].ordy, vecs[i].exp_rdy,
                 vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_sel);

        // Reset mid-transfer: pending A0 discarded at once, no handshake during reset.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("midrst_out_valid", 0, 32'(out_valid), 32'h0);
        chk("midrst_out_data", 0, 32'(out_data), 32'h0);
        chk("midrst_in_ready", 0, 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", 0, 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(100, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
        step(101, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
        step(102, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2);

`ifdef MUX_RR_PKT_LOCK_EN
        // ch2 sends a 3-word packet; ch0 joins but must wait until LAST.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_last = 4'b0000;
        step(200, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
        chk("pkt_last1", 0, 32'(out_last), 32'h0);
        step(201, 4'b0101, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
        chk("pkt_last2", 0, 32'(out_last), 32'h0);
        in_last = 4'b0100;
        step(202, 4'b0101, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
        chk("pkt_last3", 0, 32'(out_last), 32'h1);
        in_last = 4'b1111;
        step(203, 4'b0101, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
        chk("pkt_last4", 0, 32'(out_last), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-to-1 streaming multiplexer. Generalises the fixed 4:1 combinational MUX4to1 to N channels of W-bit data.
- Selection is done by an internal round-robin arbiter instead of external CTRL lines.
- Each channel has a valid/ready handshake, and a registered output stage gives full throughput.
- Sits between multiple producer blocks and a single shared consumer. Examples: shared bus port, shared UART TX, shared memory write port.

Parameters:
- N, 4, number of input channels (≥1)
- W, 8, data width per channel
- SEL_W, (N>1 ? $clog2(N) : 1), localparam, width of channel index

Ports:
- CLK  input  1  clock, rising-edge
- RST  input  1  asynchronous reset, active-high
- IN_DATA  input  N*W  channel i occupies bits [i*W +: W]
- IN_VALID  input  N  per-channel data valid
- IN_READY  output  N  per-channel accept; one-hot or zero
- OUT_DATA  output  W  registered selected data
- OUT_VALID  output  1  OUT_DATA holds an untaken word
- OUT_READY  input  1  consumer accepts OUT_DATA
- OUT_SEL  output  SEL_W  index of channel that supplied OUT_DATA

Behaviour:
- Reset (async assert, sync-safe release): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, PTR=0. IN_READY=0 combinationally while RST=1.
- LOAD = !OUT_VALID || OUT_READY. This is the output register's space-available condition.
- Arbitration (combinational):
  - Search IN_VALID starting at index PTR, wrapping modulo N.
  - The first set bit is the grant g.
  - No valid bit set means no grant.
- IN_READY[g] = LOAD && grant exists. All other IN_READY bits are 0.
- IN_READY never depends combinationally on OUT_VALID alone. It may depend on OUT_READY (pass-through ready path is allowed).
- On a clock edge with a transfer from channel g:
  - OUT_DATA <= IN_DATA[g]
  - OUT_SEL <= g
  - OUT_VALID <= 1
  - PTR <= (g==N-1) ? 0 : g+1
- On an edge with LOAD=1 and no grant: OUT_VALID <= 0. OUT_DATA and OUT_SEL hold their last values. PTR holds.
- On an edge with LOAD=0 (OUT_VALID=1, OUT_READY=0): all registers hold. Output is stable under backpressure.
- Latency: 1 cycle from input accept to OUT_VALID. Throughput: 1 word/cycle sustained.
- Fairness: with all N channels continuously valid, grants rotate 0,1,…,N-1,0. No channel waits more than N-1 transfers.
- A channel that drops IN_VALID is skipped. PTR does not advance on skipped channels, only past the granted one.
- N=1: the arbiter degenerates to a pass-through, OUT_SEL is constant 0, and PTR stays 0.
- Reset mid-transfer: the pending OUT word is discarded and the producer must re-present it. IN_READY is 0 during reset, so no handshake completes.

Optional Feature:
- Macro MUX_RR_PKT_LOCK_EN adds ports IN_LAST (input, N) and OUT_LAST (output, 1, registered alongside OUT_DATA).
- With the macro:
  - FSM state ARB: normal round-robin.
  - Transition ARB→LOCK when a transfer occurs from channel g with IN_LAST[g]=0.
  - State LOCK: grant is forced to the locked channel; other channels get IN_READY=0 even if valid.
  - Transition LOCK→ARB on a transfer with IN_LAST=1.
  - PTR advances only on the LAST transfer.
  - Reset returns the FSM to ARB.
- Without the macro: every word is an independent packet and there is no LOCK state.

Decomposition:
- Shared package mux_pkg holds:
  - function clog2_min1(n)
  - localparam-style defaults DEF_N=4, DEF_W=8
  - enum arb_state_t {ARB, LOCK}
- One natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs REQ[N] and PTR[SEL_W].
  - Outputs GNT_VLD and GNT_IDX.
  - Purely combinational.
  - Reused by later shared-resource blocks.

Test Plan:
- Reset: assert RST with IN_VALID=4'b1111 → OUT_VALID=0, IN_READY=0, OUT_SEL=0. After release, first grant is channel 0.
- Rotation: N=4, W=8, IN_DATA={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, OUT_READY=1 → OUT_DATA sequence A0,B1,C2,D3,A0 on consecutive cycles; OUT_SEL 0,1,2,3,0.
- Skip: IN_VALID=4'b1010, PTR=0 → grants 1,3,1,3. Channels 0 and 2 never see IN_READY=1.
- Backpressure: OUT_VALID=1 with OUT_DATA=8'hB1, hold OUT_READY=0 for 3 cycles → OUT_DATA, OUT_SEL and OUT_VALID stable, IN_READY=0. Release → next word loads on the following edge.
- Drain: all IN_VALID=0 with OUT_READY=1 → OUT_VALID falls one cycle after the last accept, and OUT_DATA holds its last value.
- With MUX_RR_PKT_LOCK_EN: ch2 sends a 3-word packet (LAST on word 3) while ch0 is valid → three consecutive grants to 2, OUT_LAST=1 on the third word only, and the next grant goes to channel 0.
